// File: rtl/sst_seq.sv
// Save-state sequencer: walks mapper register indices 0..REG_CNT-1 and moves
// one byte per index between the mapper save-state bus and an external buffer.
// Save copies mapper -> buffer; load copies buffer -> mapper, with each mapper
// write strobed by a CPU M2 falling edge.
module sst_seq #(
  parameter int REG_CNT = 128,
  parameter int AW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          dir,
  input  logic          abort,
  input  logic          m2_fall,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          sst_act,
  output logic [AW-1:0] sst_addr,
  output logic          sst_we_reg,
  output logic [7:0]    sst_dato,
  input  logic [7:0]    sst_di,
  output logic          buf_req,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_wdat,
  input  logic [7:0]    buf_rdat,
  input  logic          buf_ack
);

  typedef enum logic [3:0] {
    IDLE, SETUP, MAP_RD, BUF_WR, BUF_RD, MAP_WR, MAP_HOLD, NEXT, FIN
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(REG_CNT - 1);

  state_t state;
  logic   dir_q;       // 0 = save, 1 = load, frozen for the whole operation
  logic   take_abort;

  // The buffer is indexed exactly like the mapper register file.
  assign buf_addr = sst_addr;

  // Abort is only honoured at safe points; a buffer ack arriving in the same
  // cycle wins so an in-flight access always completes.
  always_comb begin
    take_abort = 1'b0;
    if (abort) begin
      case (state)
        SETUP, NEXT:    take_abort = 1'b1;
        BUF_WR, BUF_RD: take_abort = !buf_ack;
        default:        take_abort = 1'b0;
      endcase
    end
  end

  // Sequencer FSM with all bus and status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      sst_act    <= 1'b0;
      sst_addr   <= '0;
      sst_we_reg <= 1'b0;
      sst_dato   <= 8'h00;
      buf_req    <= 1'b0;
      buf_we     <= 1'b0;
      buf_wdat   <= 8'h00;
    end else begin
      done <= 1'b0;
      if (take_abort) begin
        state   <= FIN;
        done    <= 1'b1;
        aborted <= 1'b1;
        busy    <= 1'b0;
        sst_act <= 1'b0;
        buf_req <= 1'b0;
        buf_we  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              dir_q    <= dir;
              sst_addr <= '0;
              sst_act  <= 1'b1;
              aborted  <= 1'b0;
              busy     <= 1'b1;
              state    <= SETUP;
            end
          end
          SETUP: begin
            // Give the mapper one M2 edge to notice sst_act before accessing it.
            if (m2_fall) begin
              if (dir_q) begin
                buf_req <= 1'b1;
                buf_we  <= 1'b0;
                state   <= BUF_RD;
              end else begin
                state <= MAP_RD;
              end
            end
          end
          MAP_RD: begin
            buf_wdat <= sst_di;
            buf_req  <= 1'b1;
            buf_we   <= 1'b1;
            state    <= BUF_WR;
          end
          BUF_WR: begin
            if (buf_ack) begin
              buf_req <= 1'b0;
              buf_we  <= 1'b0;
              state   <= NEXT;
            end
          end
          BUF_RD: begin
            if (buf_ack) begin
              sst_dato   <= buf_rdat;
              buf_req    <= 1'b0;
              sst_we_reg <= 1'b1;
              state      <= MAP_WR;
            end
          end
          MAP_WR: begin
            // The M2 falling edge is the mapper's write strobe; hold the
            // enable until it has been seen.
            if (m2_fall) begin
              sst_we_reg <= 1'b0;
              state      <= MAP_HOLD;
            end
          end
          MAP_HOLD: begin
            state <= NEXT;
          end
          NEXT: begin
            if (sst_addr == LAST_IDX) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              sst_act <= 1'b0;
              state   <= FIN;
            end else begin
              sst_addr <= sst_addr + AW'(1);
              if (dir_q) begin
                buf_req <= 1'b1;
                buf_we  <= 1'b0;
                state   <= BUF_RD;
              end else begin
                state <= MAP_RD;
              end
            end
          end
          FIN: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sst_seq.sv
// Directed bench for sst_seq with REG_CNT=4: a combinational mapper model,
// a buffer model with programmable ack latency, and transaction logs.
module tb_sst_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, dir, abort;
  logic       m2_fall, m2_manual, m2_auto, m2_auto_p;
  logic       busy, done, aborted, sst_act, sst_we_reg;
  logic [7:0] sst_addr, sst_dato, sst_di;
  logic       buf_req, buf_we, buf_ack;
  logic [7:0] buf_addr, buf_wdat, buf_rdat;
  logic       stray_ack, hold_ack;
  int         ack_delay, wait_cnt, m2_cnt;

  logic [7:0] loadmem [4];
  logic [7:0] log_addr [32];
  logic [7:0] log_dat  [32];
  logic [7:0] mlog_addr [32];
  logic [7:0] mlog_dat  [32];
  int wr_cnt = 0, rd_cnt = 0, mw_cnt = 0, we_pulses = 0, done_cnt = 0, req_cycles = 0;
  int we_stab_err = 0, buf_stab_err = 0;
  logic       prev_we = 1'b0, pend = 1'b0, p_we = 1'b0;
  logic [7:0] prev_addr = 8'h00, prev_dato = 8'h00, p_addr = 8'h00, p_wdat = 8'h00;

  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  sst_seq #(.REG_CNT(4), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .abort(abort),
    .m2_fall(m2_fall), .busy(busy), .done(done), .aborted(aborted),
    .sst_act(sst_act), .sst_addr(sst_addr), .sst_we_reg(sst_we_reg),
    .sst_dato(sst_dato), .sst_di(sst_di), .buf_req(buf_req), .buf_we(buf_we),
    .buf_addr(buf_addr), .buf_wdat(buf_wdat), .buf_rdat(buf_rdat), .buf_ack(buf_ack)
  );

  assign sst_di   = 8'hA0 + sst_addr;
  assign buf_rdat = (buf_addr < 8'd4) ? loadmem[buf_addr[1:0]] : 8'h00;
  assign buf_ack  = (buf_req && !hold_ack && (wait_cnt == ack_delay)) || stray_ack;
  assign m2_fall  = m2_manual | m2_auto_p;

  // Free-running M2 falling-edge pulse every 5 clocks when enabled.
  always @(negedge clk) begin
    if (!m2_auto) begin
      m2_cnt    = 0;
      m2_auto_p = 1'b0;
    end else begin
      m2_auto_p = (m2_cnt == 4);
      m2_cnt    = (m2_cnt == 4) ? 0 : m2_cnt + 1;
    end
  end

  // Buffer wait-state counter.
  always @(posedge clk) begin
    if (buf_req && !buf_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // Transaction monitor and stability watchdogs.
  always @(posedge clk) begin
    if (buf_req) req_cycles <= req_cycles + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (buf_req && buf_ack && buf_we) begin
      if (wr_cnt < 32) begin
        log_addr[wr_cnt] <= buf_addr;
        log_dat[wr_cnt]  <= buf_wdat;
      end
      wr_cnt <= wr_cnt + 1;
      $display("[%0t] buf write addr=%0d data=%02h", $time, buf_addr, buf_wdat);
    end
    if (buf_req && buf_ack && !buf_we) begin
      rd_cnt <= rd_cnt + 1;
      $display("[%0t] buf read  addr=%0d data=%02h", $time, buf_addr, buf_rdat);
    end
    if (sst_we_reg && m2_fall) begin
      if (mw_cnt < 32) begin
        mlog_addr[mw_cnt] <= sst_addr;
        mlog_dat[mw_cnt]  <= sst_dato;
      end
      mw_cnt <= mw_cnt + 1;
      $display("[%0t] map write addr=%0d data=%02h", $time, sst_addr, sst_dato);
    end
    if (sst_we_reg && !prev_we) we_pulses <= we_pulses + 1;
    if (sst_we_reg && prev_we && (sst_addr != prev_addr || sst_dato != prev_dato))
      we_stab_err <= we_stab_err + 1;
    prev_we   <= sst_we_reg;
    prev_addr <= sst_addr;
    prev_dato <= sst_dato;
    if (buf_req && pend && (buf_addr != p_addr || buf_wdat != p_wdat || buf_we != p_we))
      buf_stab_err <= buf_stab_err + 1;
    pend   <= buf_req && !buf_ack;
    p_addr <= buf_addr;
    p_wdat <= buf_wdat;
    p_we   <= buf_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, wr0, mw0, d0, rq0;
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; abort = 1'b0;
    m2_manual = 1'b0; m2_auto = 1'b0; stray_ack = 1'b0; hold_ack = 1'b0;
    ack_delay = 0;
    loadmem[0] = 8'h11; loadmem[1] = 8'h22; loadmem[2] = 8'h33; loadmem[3] = 8'h44;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_flags", {25'd0, busy, done, aborted, sst_act, sst_we_reg, buf_req, buf_we}, 32'd0);
    chk("rst_data", {sst_addr, buf_addr, sst_dato, buf_wdat}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Save, zero-wait ack
    dir = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t1_busy", busy, 1); chk("t1_act", sst_act, 1); chk("t1_addr", sst_addr, 0);
    m2_manual = 1'b1;
    @(negedge clk); m2_manual = 1'b0;
    wait_done(100, n);
    chk("t1_cycles", n, 12);
    chk("t1_act_fall", sst_act, 0); chk("t1_busy_fall", busy, 0); chk("t1_aborted", aborted, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0); chk("t1_done_cnt", done_cnt, 1);
    chk("t1_wr_cnt", wr_cnt, 4); chk("t1_req_cycles", req_cycles, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), log_addr[i], i);
      chk($sformatf("t1_dat%0d", i), log_dat[i], 8'hA0 + i);
    end

    // Load, M2 every 5 cycles
    dir = 1'b1; m2_auto = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(300, n);
    chk("t2_done_seen", done, 1); chk("t2_aborted", aborted, 0);
    @(negedge clk); m2_auto = 1'b0;
    chk("t2_we_pulses", we_pulses, 4); chk("t2_mw_cnt", mw_cnt, 4);
    chk("t2_we_stable", we_stab_err, 0); chk("t2_we_low", sst_we_reg, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_addr%0d", i), mlog_addr[i], i);
      chk($sformatf("t2_dat%0d", i), mlog_dat[i], 8'h11 * (i + 1));
    end

    // Save with 3 ack wait states
    ack_delay = 3; dir = 1'b0; m2_auto = 1'b1; rq0 = req_cycles;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(300, n);
    chk("t3_done_seen", done, 1);
    @(negedge clk); m2_auto = 1'b0; ack_delay = 0;
    chk("t3_wr_cnt", wr_cnt, 8); chk("t3_req_cycles", req_cycles - rq0, 16);
    chk("t3_buf_stable", buf_stab_err, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_addr%0d", i), log_addr[4 + i], i);
      chk($sformatf("t3_dat%0d", i), log_dat[4 + i], 8'hA0 + i);
    end

    // Abort during load, BUF_RD at index 2 with ack low
    mw0 = mw_cnt; dir = 1'b1; m2_auto = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(buf_req && sst_addr == 8'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_idx2", {31'd0, buf_req && sst_addr == 8'd2}, 1);
    hold_ack = 1'b1; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t4_done", done, 1); chk("t4_aborted", aborted, 1);
    chk("t4_act", sst_act, 0); chk("t4_busy", busy, 0); chk("t4_req", buf_req, 0);
    hold_ack = 1'b0;
    repeat (10) @(negedge clk);
    m2_auto = 1'b0;
    chk("t4_mw_cnt", mw_cnt - mw0, 2); chk("t4_last_idx", mlog_addr[mw0 + 1], 1);
    chk("t4_aborted_hold", aborted, 1); chk("t4_idle", busy, 0);

    // Stray ack in IDLE, start pulsed while busy
    stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    chk("t5_stray_busy", busy, 0); chk("t5_stray_req", buf_req, 0);
    wr0 = wr_cnt; mw0 = mw_cnt; d0 = done_cnt;
    dir = 1'b0; m2_auto = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t5_aborted_clr", aborted, 0);
    repeat (3) @(negedge clk);
    dir = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; dir = 1'b0;
    wait_done(300, n);
    chk("t5_done_seen", done, 1);
    @(negedge clk);
    repeat (3) @(negedge clk);
    m2_auto = 1'b0;
    chk("t5_no_restart", busy, 0); chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_wr_cnt", wr_cnt - wr0, 4); chk("t5_mw_cnt", mw_cnt - mw0, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t5_dat%0d", i), log_dat[wr0 + i], 8'hA0 + i);

    // Asynchronous reset while waiting in MAP_WR
    mw0 = mw_cnt; dir = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    m2_manual = 1'b1;
    @(negedge clk); m2_manual = 1'b0;
    n = 0;
    while (!sst_we_reg && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_mapwr", sst_we_reg, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_we", sst_we_reg, 0); chk("t6_async_act", sst_act, 0);
    chk("t6_async_busy", busy, 0);
    @(negedge clk);
    chk("t6_no_write", mw_cnt - mw0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle", busy, 0); chk("t6_addr0", sst_addr, 0);
    wr0 = wr_cnt; dir = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t6_restart_busy", busy, 1); chk("t6_restart_addr", sst_addr, 0);
    m2_manual = 1'b1;
    @(negedge clk); m2_manual = 1'b0;
    wait_done(100, n);
    chk("t6_cycles", n, 12);
    @(negedge clk);
    chk("t6_wr_cnt", wr_cnt - wr0, 4); chk("t6_first_addr", log_addr[wr0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sst_seq.md
# sst_seq

Save-state sequencer for the mapper save-state register bus. On a command it walks mapper register indices 0..REG_CNT-1 and moves each byte between the mapper and an external state buffer:

- **Save:** reads the mapper's `sst_di` and writes it to the buffer.
- **Load:** reads the buffer and writes the mapper through `sst_we_reg`, aligned to CPU M2 falling edges.

It sits between the host/menu controller and the active mapper, and owns `sst.act` for the whole operation.

## Interface
Parameters:
- `REG_CNT`, 128: number of register indices walked. Range 2..256.
- `AW`, 8: width of `sst_addr` and `buf_addr`.

Ports:
- `clk`  in  1  system clock. All logic is synchronous to `clk`, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  command strobe. Sampled only in IDLE.
- `dir`  in  1  0 = save (mapper→buffer), 1 = load (buffer→mapper). Latched on an accepted `start`.
- `abort`  in  1  terminates the operation at the next state boundary.
- `m2_fall`  in  1  one-`clk` pulse per CPU M2 falling edge, already synchronised.
- `busy`  out  1  high from an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse. Also pulses on abort.
- `aborted`  out  1  registered with `done`. Holds its value until the next accepted `start`.
- `sst_act`  out  1  save-state bus active to the mapper.
- `sst_addr`  out  AW  register index to the mapper.
- `sst_we_reg`  out  1  mapper register write enable.
- `sst_dato`  out  8  data to the mapper.
- `sst_di`  in  8  data from the mapper.
- `buf_req`  out  1  buffer access request.
- `buf_we`  out  1  1 = write the buffer.
- `buf_addr`  out  AW  buffer index. Always equal to `sst_addr`.
- `buf_wdat`  out  8  buffer write data.
- `buf_rdat`  in  8  buffer read data. Valid in the cycle `buf_ack` is high.
- `buf_ack`  in  1  access complete.

## Operation
States: IDLE, SETUP, MAP_RD, BUF_WR, BUF_RD, MAP_WR, MAP_HOLD, NEXT, FIN.

- **IDLE**
  - `start` → SETUP. `dir` is latched, `sst_addr` is set to 0, `sst_act` is set to 1, `aborted` is cleared.
- **SETUP**
  - Waits for `m2_fall`, so the mapper's clock domain sees `sst_act` before any access.
  - Then → MAP_RD if save, or → BUF_RD if load.
- **MAP_RD** (save)
  - 1 cycle. Captures `sst_di` into `buf_wdat`, then → BUF_WR.
- **BUF_WR** (save)
  - `buf_req=1`, `buf_we=1`, held until `buf_ack`.
  - On `buf_ack` → NEXT.
- **BUF_RD** (load)
  - `buf_req=1`, `buf_we=0`, held until `buf_ack`.
  - On `buf_ack`, latches `buf_rdat` into `sst_dato` → MAP_WR.
- **MAP_WR** (load)
  - `sst_we_reg=1`.
  - Waits for `m2_fall`, which is the mapper's write strobe → MAP_HOLD.
- **MAP_HOLD** (load)
  - `sst_we_reg=0`, 1 cycle → NEXT.
  - This guarantees exactly one mapper write per index.
- **NEXT**
  - If `sst_addr == REG_CNT-1` → FIN.
  - Otherwise increment `sst_addr` and → MAP_RD (save) or SETUP-free BUF_RD (load).
- **FIN**
  - `sst_act=0`, `done=1` for 1 cycle, `busy=0` → IDLE.

Boundary rules:
- `start` outside IDLE is ignored.
- `abort` is sampled in SETUP, NEXT, and in BUF_WR/BUF_RD only when `buf_ack` is low.
  - An abort goes to FIN with `aborted=1`.
  - An abort is never taken while `buf_req` is waiting on a pending `buf_ack` that arrives in the same cycle; the ack wins and the abort is taken at the next NEXT.
  - `sst_we_reg` is never dropped before the `m2_fall` it was waiting for.
- `buf_ack` is honoured only while `buf_req` is high. Stray acks are ignored.
- `sst_addr` never wraps. The last index processed is REG_CNT-1.
- `m2_fall` arriving outside SETUP and MAP_WR is ignored. In MAP_WR it is consumed once.
- Asynchronous reset mid-operation: all outputs go to 0 immediately and the state returns to IDLE. No partial write is completed.

Reset values: `busy`, `done`, `aborted`, `sst_act`, `sst_we_reg`, `buf_req`, `buf_we` are 0. `sst_addr`, `buf_addr`, `sst_dato`, `buf_wdat` are 0.

## Timing
- **Save, per index:** MAP_RD (1) + BUF_WR (1 + ack latency) + NEXT (1).
  - With zero-wait ack (ack in the first cycle of `buf_req`): 3 cycles per index.
- **Load, per index:** BUF_RD (≥1) + MAP_WR (until `m2_fall`) + MAP_HOLD (1) + NEXT (1).
- `done` asserts in the cycle after NEXT at the last index. `sst_act` falls in that same cycle.
- `sst_addr` and `sst_dato` are stable for the whole time `sst_we_reg` is high.
- `buf_addr`, `buf_we` and `buf_wdat` are stable while `buf_req` is high.
- `busy` rises the cycle after an accepted `start`.

## Test plan
- **Save, REG_CNT=4, zero-wait ack:** mapper returns `sst_di = 8'hA0+addr`.
  - Buffer receives writes 0:A0, 1:A1, 2:A2, 3:A3.
  - `done` pulses once. Total cycles after `m2_fall` is 12.
- **Load, REG_CNT=4, buffer contents 11, 22, 33, 44, `m2_fall` every 5 cycles.**
  - Exactly four `sst_we_reg` pulses.
  - Each pulse ends after `m2_fall`, with `sst_dato` = 11/22/33/44 at addr 0..3.
- **Ack wait states:** `buf_ack` delayed 3 cycles on every access.
  - `buf_req`, `buf_addr` and `buf_wdat` hold unchanged.
  - Data is identical to the zero-wait run.
- **Abort during load at addr 2, while in BUF_RD with ack low.**
  - FIN next cycle. `done=1`, `aborted=1`, `sst_act` drops.
  - Indices 2 and 3 are never written.
- **`start` pulsed while busy, plus a stray `buf_ack` in IDLE.**
  - Neither is accepted; the operation completes normally.
  - No extra buffer or mapper accesses occur.
- **`rst_n` low during MAP_WR.**
  - `sst_we_reg`, `sst_act` and `busy` go to 0 asynchronously.
  - After release, the block is in IDLE and a new `start` begins at addr 0.
